// File: rtl/alu_pkg.sv
// Shared constants, opcode set, legality check and arbiter state type for alu_share_arb.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 5;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 5'd7;
  localparam logic [ALU_OP_W-1:0] OP_NOR  = 5'd8;
  localparam logic [ALU_OP_W-1:0] OP_SLL  = 5'd9;
  localparam logic [ALU_OP_W-1:0] OP_SRL  = 5'd10;
  localparam logic [ALU_OP_W-1:0] OP_SRA  = 5'd11;
  localparam logic [ALU_OP_W-1:0] OP_SLT  = 5'd12;
  localparam logic [ALU_OP_W-1:0] OP_SLTU = 5'd13;
  localparam logic [ALU_OP_W-1:0] OP_LUI  = 5'd14;
  localparam logic [ALU_OP_W-1:0] OP_MUL  = 5'd15;
  localparam logic [ALU_OP_W-1:0] OP_MULH = 5'd16;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  function automatic logic is_legal_aluop(input logic [ALU_OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
      OP_SRA, OP_SLT, OP_SLTU, OP_LUI, OP_MUL, OP_MULH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int              k;
  logic [ID_W-1:0] k_idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    k     = 0;
    k_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      k     = (int'(ptr) + off) % NUM_REQ;
      k_idx = ID_W'(k);
      if (req[k_idx]) begin
        gnt        = '0;
        gnt[k_idx] = 1'b1;
        idx        = k_idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Optional per-requester grant counters when ALU_ARB_STATS_EN is defined.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = ALU_DATA_W,
  parameter  int OP_W    = ALU_OP_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in_1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in_2,
  input  logic [NUM_REQ*OP_W-1:0]   req_aluop,
  output logic [DATA_W-1:0]         alu_in_1,
  output logic [DATA_W-1:0]         alu_in_2,
  output logic [OP_W-1:0]           alu_aluop,
  input  logic [DATA_W-1:0]         alu_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic                      busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] in1_arr [NUM_REQ];
  logic [DATA_W-1:0] in2_arr [NUM_REQ];
  logic [OP_W-1:0]   op_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign in1_arr[gi] = req_in_1[gi*DATA_W +: DATA_W];
    assign in2_arr[gi] = req_in_2[gi*DATA_W +: DATA_W];
    assign op_arr[gi]  = req_aluop[gi*OP_W +: OP_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          in1_d     = in1_arr[pick_idx];
          in2_d     = in2_arr[pick_idx];
          op_d      = op_arr[pick_idx];
          id_d      = pick_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Illegal opcodes still go through the ALU; only the error flag marks them.
        rsp_data_d = alu_out;
        rsp_err_d  = ~is_legal_aluop(ALU_OP_W'(op_q));
        rr_ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Operands stay parked on the last latched values; only the opcode is gated.
  assign alu_in_1  = in1_q;
  assign alu_in_2  = in2_q;
  assign alu_aluop = (state_q == EXEC) ? op_q : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && pick_gnt[gi] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: transaction-level model checked every cycle, plus literal pins.
module tb_alu_share_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 5;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_in_1, req_in_2;
  logic [N*OW-1:0] req_aluop;
  logic [DW-1:0]   alu_in_1, alu_in_2, alu_out, rsp_data;
  logic [OW-1:0]   alu_aluop;
  logic            rsp_valid, rsp_ready, rsp_err, busy;
  logic [IW-1:0]   rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int tb_cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Stand-in for alu_top: any deterministic function of the three inputs will do.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      default: return a ^ b ^ {27'd0, op};
    endcase
  endfunction

  function automatic bit legal_op(input logic [OW-1:0] op);
    return op inside {[5'd1:5'd2], [5'd5:5'd16]};
  endfunction

  assign alu_out = alu_f(alu_in_1, alu_in_2, alu_aluop);

  alu_share_arb #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in_1  (req_in_1),
    .req_in_2  (req_in_2),
    .req_aluop (req_aluop),
    .alu_in_1  (alu_in_1),
    .alu_in_2  (alu_in_2),
    .alu_aluop (alu_aluop),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Transaction-level model: one outstanding op, timeline grant -> exec -> respond.
  bit            m_busy  = 0;
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_id    = 0;
  logic [DW-1:0] m_a, m_b, m_last_a, m_last_b;
  logic [OW-1:0] m_op;
  int            m_cnt [N];

  initial begin
    m_a = '0; m_b = '0; m_op = '0; m_last_a = '0; m_last_b = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int w;
    int k;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu_in_1", alu_in_1, 0);
      chk("rst_alu_in_2", alu_in_2, 0);
      chk("rst_alu_aluop", alu_aluop, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      m_busy = 0; m_phase = 0; m_ptr = 0; m_last_a = '0; m_last_b = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      exp_rdy = '0;
      w = -1;
      if (!m_busy) begin
        for (int o = 0; o < N; o++) begin
          k = (m_ptr + o) % N;
          if (w < 0 && req_valid[k]) w = k;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, (m_busy && m_phase == 2));
      chk("alu_aluop", alu_aluop, (m_busy && m_phase == 1) ? m_op : 5'd0);
      chk("alu_in_1", alu_in_1, m_last_a);
      chk("alu_in_2", alu_in_2, m_last_b);
      if (m_busy && m_phase == 2) begin
        chk("rsp_data", rsp_data, alu_f(m_a, m_b, m_op));
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, !legal_op(m_op));
      end
`ifdef ALU_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
      if (!m_busy && w >= 0) begin
        m_id = w;
        m_a  = req_in_1[w*DW +: DW];
        m_b  = req_in_2[w*DW +: DW];
        m_op = req_aluop[w*OW +: OW];
        m_last_a = m_a;
        m_last_b = m_b;
        m_busy = 1; m_phase = 1;
        m_ptr = (w + 1) % N;
        if (m_cnt[w] < 65535) m_cnt[w]++;
        $display("grant req%0d a=%0h b=%0h op=%0d", w, m_a, m_b, m_op);
      end else if (m_busy && m_phase == 1) begin
        m_phase = 2;
      end else if (m_busy && m_phase == 2 && rsp_ready) begin
        m_busy = 0;
        $display("rsp   req%0d data=%0h err=%0b", m_id, rsp_data, rsp_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
    req_in_1[i*DW +: DW] = a;
    req_in_2[i*DW +: DW] = b;
    req_aluop[i*OW +: OW] = op;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    if (n >= 50) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_any_grant(output int idx, output int at_cyc);
    int n = 0;
    idx = -1;
    at_cyc = 0;
    while (n < 50 && idx < 0) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
      at_cyc = tb_cyc;
      n++;
    end
    if (idx < 0) chk("any_grant_timeout", 0, 1);
  endtask

  int g_idx [5];
  int g_cyc [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_valid = '0; rsp_ready = 1'b1;
    req_in_1 = '0; req_in_2 = '0; req_aluop = '0;
    #1 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // All requesters valid: strict rotation, one grant per 3 cycles.
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + i, 32'h10 * i, 5'(i + 5));
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_any_grant(g_idx[g], g_cyc[g]);
      chk("rot_order", g_idx[g], exp_order[g]);
      if (g > 0) chk("rot_spacing", g_cyc[g] - g_cyc[g-1], 3);
    end
    step();
    req_valid = '0;
    repeat (4) step();

    // Single request: latency and operand/opcode presentation.
    set_req(0, 32'd5, 32'd6, 5'd1);
    req_valid = 4'b0001;
    wait_grant(0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_alu_in_1", alu_in_1, 32'd5);
    chk("t1_alu_in_2", alu_in_2, 32'd6);
    chk("t1_alu_aluop", alu_aluop, 5'd1);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 32'd11);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_err", rsp_err, 0);
    repeat (2) step();

    // Lone requester held valid wins back-to-back slots.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 5'd2);
    req_valid = 4'b0001;
    wait_any_grant(g_idx[0], g_cyc[0]);
    wait_any_grant(g_idx[1], g_cyc[1]);
    chk("solo_first", g_idx[0], 0);
    chk("solo_second", g_idx[1], 0);
    chk("solo_spacing", g_cyc[1] - g_cyc[0], 3);
    step();
    req_valid = '0;
    repeat (4) step();

    // Illegal opcode still executes but is flagged.
    set_req(2, 32'd5, 32'd5, 5'd3);
    req_valid = 4'b0100;
    wait_grant(2);
    step();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("ill_rsp_valid", rsp_valid, 1);
    chk("ill_rsp_err", rsp_err, 1);
    chk("ill_rsp_id", rsp_id, 2);
    chk("ill_rsp_data", rsp_data, 32'd3);
    repeat (2) step();

    // Consumer stall: response held, other requesters locked out.
    rsp_ready = 1'b0;
    set_req(1, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5);
    req_valid = 4'b0010;
    wait_grant(1);
    step();
    req_valid = 4'b1101;
    repeat (6) step();
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("stall_rsp_valid", rsp_valid, 1);
    chk("stall_rsp_data", rsp_data, 32'h0000_FF05);
    @(negedge clk);
    chk("stall_idle_busy", busy, 0);
    chk("stall_idle_valid", rsp_valid, 0);
    repeat (2) step();

    // Reset during EXEC discards the op and restarts rotation at 0.
    set_req(3, 32'd7, 32'd9, 5'd6);
    req_valid = 4'b1000;
    wait_grant(3);
    step();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_aluop", alu_aluop, 0);
    chk("mid_rst_alu_in_1", alu_in_1, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    repeat (4) step();

`ifdef ALU_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(1, 32'd1, 32'd2, 5'd1);
    for (int g = 0; g < 3; g++) begin
      req_valid = 4'b0010;
      wait_grant(1);
      step();
      req_valid = '0;
      repeat (3) step();
    end
    chk("stats_cnt1", grant_cnt[16 +: 16], 16'd3);
    chk("stats_cnt0", grant_cnt[0 +: 16], 16'd0);
    chk("stats_cnt2", grant_cnt[32 +: 16], 16'd0);
    chk("stats_cnt3", grant_cnt[48 +: 16], 16'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one combinational alu_top instance among NUM_REQ requesters.
- Each requester presents an operand pair and a 5-bit aluop with a valid/ready handshake.
- The block latches the winning request, drives the ALU for one cycle, registers alu_out, and returns the result with the requester ID over a valid/ready response channel.
- Sits between the issue logic of the client blocks and alu_top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width (matches alu_top)
- OP_W, 5, aluop width (matches alu_top)
- ID_W, $clog2(NUM_REQ), requester ID width (derived localparam, not overridable)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- req_in_1  in  NUM_REQ*DATA_W  flattened operand 1, requester i at [i*DATA_W +: DATA_W]
- req_in_2  in  NUM_REQ*DATA_W  flattened operand 2
- req_aluop  in  NUM_REQ*OP_W  flattened opcode
- alu_in_1  out  DATA_W  to alu_top in_1
- alu_in_2  out  DATA_W  to alu_top in_2
- alu_aluop  out  OP_W  to alu_top aluop
- alu_out  in  DATA_W  from alu_top alu_out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  registered ALU result
- rsp_id  out  ID_W  index of the requester served
- rsp_err  out  1  aluop outside the legal set
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rr_ptr=0; req_ready=0; latched operands, latched aluop, rsp_data, rsp_id, rsp_err=0; rsp_valid=0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, the winner is the first asserted index searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Latch the winner's in_1, in_2, aluop and ID.
  - req_ready[winner]=1 combinationally in this cycle only; the handshake completes on this edge. Go to EXEC.
  - If no req_valid, stay in IDLE with req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_in_1/alu_in_2/alu_aluop driven from the latched values.
  - At the clock edge, rsp_data<=alu_out and rsp_err<=illegal(aluop).
  - rr_ptr<=(winner+1) mod NUM_REQ. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new request is accepted in RESP.
- Outside EXEC: alu_in_1/alu_in_2 hold the last latched values (no toggling) and alu_aluop=0.
- Latency: request accepted in cycle T -> rsp_valid in cycle T+2. Peak throughput is 1 op per 3 cycles.
- Legal aluop set: 1, 2, 5..16. Illegal codes (0, 3, 4, 17..31) are still issued to the ALU; rsp_err=1 and rsp_data = whatever alu_out returned.
- Arithmetic: no width changes; the result passes through unmodified.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - A single requester continuously valid gets every slot.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - req_valid dropped before grant: ignored, no obligation.
  - rsp_ready held low: the block stalls in RESP indefinitely.
- Reset mid-operation: the in-flight request is discarded without a response. A requester that already saw req_ready must reissue.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- With the macro defined: extra output grant_cnt, width NUM_REQ*16, reset 0. Counter i increments on each grant to requester i and saturates at 16'hFFFF.
- Without it: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W/OP_W constants
  - aluop localparams for codes 1, 2, 5..16
  - is_legal_aluop function
  - arbiter state enum (IDLE/EXEC/RESP)
- One sub-module is natural: rr_pick. It is a combinational round-robin picker taking req vector and rr_ptr, and producing a one-hot grant plus binary index.

Test Plan:
- Req0 only, in_1=5, in_2=6, aluop=1 at cycle T -> req_ready[0] pulses at T; alu_in_1=5, alu_in_2=6, alu_aluop=1 during T+1; rsp_valid at T+2 with rsp_id=0, rsp_data equal to the alu_top model result for (5,6,1), rsp_err=0.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; a new grant every 3 cycles.
- Req2 issues aluop=3, in_1=5, in_2=5 -> rsp_err=1, rsp_id=2, rsp_data equals the model output.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_id stable throughout; no req_ready pulses; IDLE entered the cycle after rsp_ready=1.
- rst_n asserted during EXEC -> all outputs 0 immediately; no rsp_valid; after release the next grant goes to requester 0.
- With ALU_ARB_STATS_EN, 3 grants to req1 -> grant_cnt[16 +: 16]=3; all other counters are 0.
